// File: rtl/approx_mult_err_monitor.sv
// Error monitor for an external 4x4 approximate multiplier. It sweeps all 256 operand pairs and
// accumulates the error count, the sum of error distances and the maximum error distance.
// Define APPROX_MULT_MRED_EN to add the mred_sum output, the relative-error accumulator.
module approx_mult_err_monitor #(
    parameter int SETTLE_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  op_a,
    output logic [3:0]  op_b,
    input  logic [7:0]  approx_in,
    output logic        busy,
    output logic        done,
    output logic [8:0]  err_count,
    output logic [15:0] sum_ed,
    output logic [7:0]  max_ed
`ifdef APPROX_MULT_MRED_EN
    ,
    output logic [23:0] mred_sum
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  idx;
    logic [3:0]  settle_cnt;
    logic        sample;
    logic        last_vec;
    logic [7:0]  exact;
    logic [7:0]  ed;

    // idx is a register, so the operands leave the block registered and read 0 outside a sweep.
    assign op_a     = idx[7:4];
    assign op_b     = idx[3:0];
    assign last_vec = (idx == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    sample = 1'b1;
                    if (last_vec) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Exact product and absolute error distance. The subtraction direction is chosen so the result never wraps.
    always_comb begin
        exact = {4'b0000, op_a} * {4'b0000, op_b};
        if (approx_in >= exact) begin
            ed = approx_in - exact;
        end else begin
            ed = exact - approx_in;
        end
    end

`ifdef APPROX_MULT_MRED_EN
    logic [15:0] mred_q;

    always_comb begin
        mred_q = 16'd0;
        if (exact != 8'd0) begin
            mred_q = {ed, 8'h00} / {8'h00, exact};
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 8'd0;
            settle_cnt <= 4'd0;
            err_count  <= 9'd0;
            sum_ed     <= 16'd0;
            max_ed     <= 8'd0;
`ifdef APPROX_MULT_MRED_EN
            mred_sum   <= 24'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= 8'd0;
                        settle_cnt <= 4'd0;
                        err_count  <= 9'd0;
                        sum_ed     <= 16'd0;
                        max_ed     <= 8'd0;
`ifdef APPROX_MULT_MRED_EN
                        mred_sum   <= 24'd0;
`endif
                    end
                end
                SWEEP: begin
                    if (sample) begin
                        settle_cnt <= 4'd0;
                        // After the last vector, idx returns to 0 instead of starting a second sweep.
                        idx        <= last_vec ? 8'd0 : idx + 8'd1;
                        sum_ed     <= sum_ed + {8'h00, ed};
                        if (ed != 8'd0) begin
                            err_count <= err_count + 9'd1;
                        end
                        if (ed > max_ed) begin
                            max_ed <= ed;
                        end
`ifdef APPROX_MULT_MRED_EN
                        if (exact != 8'd0) begin
                            mred_sum <= mred_sum + {8'h00, mred_q};
                        end
`endif
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    idx        <= 8'd0;
                    settle_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor. It runs two instances, with SETTLE_CYC=0 and SETTLE_CYC=2,
// each driven by a behavioural multiplier model whose error pattern is selected by 'mode'.
module tb_approx_mult_err_monitor;

    localparam int S0 = 0;
    localparam int S2 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start2;
    logic [3:0]  op_a0, op_b0, op_a2, op_b2;
    logic [7:0]  approx0, approx2;
    logic        busy0, done0, busy2, done2;
    logic [8:0]  err0, err2;
    logic [15:0] sum0, sum2;
    logic [7:0]  max0, max2;
`ifdef APPROX_MULT_MRED_EN
    logic [23:0] mred0, mred2;
`endif

    int mode = 0;
    int checks = 0;
    int failures = 0;
    int lat, bcyc, nd, obad, bafter;
    bit tmo;

    always #5 clk = ~clk;

    // Modes: 0 exact, 1 zero, 2 exact+1, 3 2*exact (8-bit), 4 sparse errors, 5 constant 255
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input int m);
        logic [7:0] e;
        e = {4'b0000, a} * {4'b0000, b};
        case (m)
            0: return e;
            1: return 8'd0;
            2: return e + 8'd1;
            3: return {e[6:0], 1'b0};
            4: begin
                if (a == b) return e + 8'd3;
                else if (a == 4'd15 && b == 4'd1) return e - 8'd10;
                else return e;
            end
            default: return 8'hFF;
        endcase
    endfunction

    assign approx0 = model(op_a0, op_b0, mode);
    assign approx2 = model(op_a2, op_b2, mode);

    approx_mult_err_monitor #(.SETTLE_CYC(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .op_a(op_a0), .op_b(op_b0), .approx_in(approx0),
        .busy(busy0), .done(done0),
        .err_count(err0), .sum_ed(sum0), .max_ed(max0)
`ifdef APPROX_MULT_MRED_EN
        , .mred_sum(mred0)
`endif
    );

    approx_mult_err_monitor #(.SETTLE_CYC(S2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .op_a(op_a2), .op_b(op_b2), .approx_in(approx2),
        .busy(busy2), .done(done2),
        .err_count(err2), .sum_ed(sum2), .max_ed(max2)
`ifdef APPROX_MULT_MRED_EN
        , .mred_sum(mred2)
`endif
    );

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start2 = v;
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy2;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : done2;
    endfunction

    function automatic logic [7:0] get_op(input int sel);
        return (sel == 0) ? {op_a0, op_b0} : {op_a2, op_b2};
    endfunction

    // Drives one sweep from a negedge. latency counts negedges from the start request to the first done,
    // and the operand order is tracked against the busy-cycle count.
    task automatic run_sweep(input int sel, input int restart_at, input bit poke_done);
        int settle;
        int post;
        bit fin;
        settle = (sel == 0) ? S0 : S2;
        post = 0; fin = 1'b0;
        lat = 0; bcyc = 0; nd = 0; obad = 0; bafter = 0;
        set_start(sel, 1'b1);
        for (int c = 1; c <= 4000 && !fin; c++) begin
            @(negedge clk);
            set_start(sel, 1'b0);
            if (nd > 0 && get_busy(sel)) begin
                bafter++;
            end else if (get_busy(sel)) begin
                if (get_op(sel) !== 8'(bcyc / (settle + 1))) obad++;
                bcyc++;
                if (bcyc == restart_at) set_start(sel, 1'b1);
            end
            if (get_done(sel)) begin
                nd++;
                if (nd == 1) begin
                    lat = c;
                    if (poke_done) set_start(sel, 1'b1);
                end
            end
            if (nd > 0) begin
                post++;
                if (post == 6) fin = 1'b1;
            end
        end
        tmo = !fin;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start0 = 1'b0; start2 = 1'b0; mode = 0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, op_a0, op_b0} !== 10'd0) begin
            failures++;
            $display("FAIL reset_ctrl0: got busy=%b done=%b op_a=%0d op_b=%0d, required all 0", busy0, done0, op_a0, op_b0);
        end
        checks++;
        if ({err0, sum0, max0} !== 33'd0) begin
            failures++;
            $display("FAIL reset_acc0: got err=%0d sum=%0d max=%0d, required all 0", err0, sum0, max0);
        end
        checks++;
        if ({busy2, done2, op_a2, op_b2, err2, sum2, max2} !== 43'd0) begin
            failures++;
            $display("FAIL reset_dut2: got busy=%b done=%b err=%0d sum=%0d max=%0d, required all 0", busy2, done2, err2, sum2, max2);
        end
`ifdef APPROX_MULT_MRED_EN
        checks++;
        if (mred0 !== 24'd0) begin
            failures++;
            $display("FAIL reset_mred: got %0d required 0", mred0);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exact_timing();
        mode = 0;
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: got %b required 0", busy0);
        end
        run_sweep(0, -1, 1'b0);
        checks++;
        if (tmo) begin
            failures++;
            $display("FAIL exact_timeout: no done within budget");
        end
        checks++;
        if (lat != 257) begin
            failures++;
            $display("FAIL exact_done_latency: got %0d required 257", lat);
        end
        checks++;
        if (bcyc != 256 || nd != 1) begin
            failures++;
            $display("FAIL exact_busy_done: busy cycles %0d done pulses %0d, required 256 and 1", bcyc, nd);
        end
        checks++;
        if ({err0, sum0, max0} !== 33'd0) begin
            failures++;
            $display("FAIL exact_results: got err=%0d sum=%0d max=%0d, required 0/0/0", err0, sum0, max0);
        end
    endtask

    task automatic test_zero_and_hold();
        mode = 1;
        run_sweep(0, -1, 1'b0);
        checks++;
        if (err0 !== 9'd225 || sum0 !== 16'd14400 || max0 !== 8'd225) begin
            failures++;
            $display("FAIL zero_results: got err=%0d sum=%0d max=%0d, required 225/14400/225", err0, sum0, max0);
        end
        mode = 5;
        repeat (10) @(negedge clk);
        checks++;
        if (err0 !== 9'd225 || sum0 !== 16'd14400 || max0 !== 8'd225) begin
            failures++;
            $display("FAIL zero_hold: got err=%0d sum=%0d max=%0d, required 225/14400/225", err0, sum0, max0);
        end
        checks++;
        if ({op_a0, op_b0, busy0, done0} !== 10'd0) begin
            failures++;
            $display("FAIL idle_ops: got op_a=%0d op_b=%0d busy=%b done=%b, required 0", op_a0, op_b0, busy0, done0);
        end
    endtask

    task automatic test_plus_one();
        mode = 2;
        run_sweep(0, -1, 1'b0);
        checks++;
        if (obad != 0 || bcyc != 256) begin
            failures++;
            $display("FAIL plus_one_order: out-of-order vectors %0d busy cycles %0d, required 0 and 256", obad, bcyc);
        end
        checks++;
        if (err0 !== 9'd256 || sum0 !== 16'd256 || max0 !== 8'd1) begin
            failures++;
            $display("FAIL plus_one_results: got err=%0d sum=%0d max=%0d, required 256/256/1", err0, sum0, max0);
        end
    endtask

    task automatic test_saturate();
        mode = 5;
        run_sweep(0, -1, 1'b0);
        checks++;
        if (err0 !== 9'd256 || sum0 !== 16'd50880 || max0 !== 8'd255) begin
            failures++;
            $display("FAIL const255_results: got err=%0d sum=%0d max=%0d, required 256/50880/255", err0, sum0, max0);
        end
    endtask

    task automatic test_start_ignored();
        mode = 4;
        run_sweep(0, 100, 1'b1);
        checks++;
        if (nd != 1 || bafter != 0 || bcyc != 256 || lat != 257) begin
            failures++;
            $display("FAIL restart_ignored: done pulses %0d busy-after %0d busy cycles %0d latency %0d, required 1/0/256/257", nd, bafter, bcyc, lat);
        end
        checks++;
        if (err0 !== 9'd17 || sum0 !== 16'd58 || max0 !== 8'd10) begin
            failures++;
            $display("FAIL pattern_results: got err=%0d sum=%0d max=%0d, required 17/58/10", err0, sum0, max0);
        end
    endtask

    task automatic test_settle2();
        mode = 4;
        run_sweep(1, -1, 1'b0);
        checks++;
        if (tmo || lat != 769 || bcyc != 768 || nd != 1) begin
            failures++;
            $display("FAIL settle2_timing: latency %0d busy cycles %0d done pulses %0d, required 769/768/1", lat, bcyc, nd);
        end
        checks++;
        if (obad != 0) begin
            failures++;
            $display("FAIL settle2_order: got %0d mis-ordered cycles required 0", obad);
        end
        checks++;
        if (err2 !== 9'd17 || sum2 !== 16'd58 || max2 !== 8'd10) begin
            failures++;
            $display("FAIL settle2_results: got err=%0d sum=%0d max=%0d, required 17/58/10", err2, sum2, max2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int stray;
        mode = 1;
        start0 = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        // 49 vectors sampled so far: a=1 and a=2 rows, each with b in 1..15
        checks++;
        if (err0 !== 9'd30 || sum0 !== 16'd360 || max0 !== 8'd30 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL midsweep_partial: got err=%0d sum=%0d max=%0d busy=%b, required 30/360/30/1", err0, sum0, max0, busy0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy0, done0, op_a0, op_b0, err0, sum0, max0} !== 43'd0) begin
            failures++;
            $display("FAIL midsweep_reset: got busy=%b done=%b op=%0d/%0d err=%0d sum=%0d max=%0d, required all 0",
                     busy0, done0, op_a0, op_b0, err0, sum0, max0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done0 || busy0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midsweep_no_done: got %0d busy/done cycles required 0", stray);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, -1, 1'b0);
        checks++;
        if (lat != 257 || err0 !== 9'd225 || sum0 !== 16'd14400 || max0 !== 8'd225) begin
            failures++;
            $display("FAIL post_reset_sweep: latency %0d err=%0d sum=%0d max=%0d, required 257/225/14400/225", lat, err0, sum0, max0);
        end
    endtask

`ifdef APPROX_MULT_MRED_EN
    task automatic test_mred();
        int exp_mred;
        int e, ap, d;
        exp_mred = 0;
        // 2*exact is truncated to 8 bits, so products of 128 and above leave the 256-per-vector case.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e  = a * b;
                ap = (2 * e) % 256;
                d  = (ap > e) ? ap - e : e - ap;
                if (e != 0) exp_mred += (d * 256) / e;
            end
        end
        mode = 3;
        run_sweep(0, -1, 1'b0);
        checks++;
        if (mred0 !== 24'(exp_mred)) begin
            failures++;
            $display("FAIL mred_sum: got %0d required %0d", mred0, exp_mred);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_exact_timing();
        test_zero_and_hold();
        test_plus_one();
        test_saturate();
        test_start_ignored();
        test_settle2();
        test_reset_mid_sweep();
`ifdef APPROX_MULT_MRED_EN
        test_mred();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
